// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and the byte-strobe merge helper.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Replace each byte of old with the matching byte of data where strb is set.
    function automatic logic [31:0] merge_strb(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = data[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_lite_chan_slot.sv
// One-entry holding register for an AXI4-Lite request channel (AW or W).
// The ready output is a flop tracking the next-state emptiness of the slot,
// so there is no combinational path from valid to ready.
module axi4_lite_chan_slot #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    output logic         ready,
    input  logic [W-1:0] in_data,
    input  logic         clear,
    output logic         full,
    output logic [W-1:0] out_data
);

    logic hs;
    logic full_next;

    // Next occupancy: a handshake fills, a clear empties.
    // Both cannot coincide: clear only fires while full, when ready is 0.
    always_comb begin
        hs        = valid & ready;
        full_next = full;
        if (clear) begin
            full_next = 1'b0;
        end
        if (hs) begin
            full_next = 1'b1;
        end
    end

    // Occupancy, registered ready and captured payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= 1'b0;
            ready    <= 1'b0;
            out_data <= '0;
        end else begin
            full  <= full_next;
            ready <= !full_next;
            if (hs) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/axi4_lite_write_slave.sv
// AXI4-Lite write subordinate: independent one-entry AW and W slots, a commit
// stage that merges the write into a register file under WSTRB, and a single
// registered B response. A side port reads the register file combinationally.
module axi4_lite_write_slave
    import axi4_lite_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = 32,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned NUM_REGS   = 16,
    localparam int unsigned IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [2:0]            AWPROT,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [3:0]            WSTRB,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [1:0]            BRESP,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

    logic                  aw_full;
    logic                  w_full;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [3:0]            w_strb;
    logic                  commit;
    logic                  in_range;
    logic [IDX_W-1:0]      wr_idx;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Protection attributes are accepted but have no effect here.
    logic unused_prot;
    assign unused_prot = ^AWPROT;

    axi4_lite_chan_slot #(
        .W (ADDR_WIDTH)
    ) u_aw_slot (
        .clk      (ACLK),
        .rst      (ARESET),
        .valid    (AWVALID),
        .ready    (AWREADY),
        .in_data  (AWADDR),
        .clear    (commit),
        .full     (aw_full),
        .out_data (aw_addr)
    );

    axi4_lite_chan_slot #(
        .W (DATA_WIDTH + 4)
    ) u_w_slot (
        .clk      (ACLK),
        .rst      (ARESET),
        .valid    (WVALID),
        .ready    (WREADY),
        .in_data  ({WDATA, WSTRB}),
        .clear    (commit),
        .full     (w_full),
        .out_data ({w_data, w_strb})
    );

    // Commit only once both halves are present and the previous response has
    // drained; a B handshake therefore always precedes the next commit by an edge.
    always_comb begin
        commit   = aw_full & w_full & !bvalid_q;
        in_range = aw_addr < ADDR_LIMIT;
        wr_idx   = aw_addr[2 +: IDX_W];
    end

    // B channel: raised by a commit, held stable until BREADY is seen.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && BREADY) begin
            bvalid_q <= 1'b0;
        end
    end

    // Register file: byte-merged write on an in-range commit.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (commit && in_range) begin
            regs[wr_idx] <= merge_strb(regs[wr_idx], w_data, w_strb);
        end
    end

    // Output drive: registered B channel and the combinational side read.
    always_comb begin
        BVALID  = bvalid_q;
        BRESP   = bresp_q;
        rd_data = regs[rd_idx];
    end

endmodule

// File: tb/tb_axi4_lite_write_slave.sv
// Self-checking bench for axi4_lite_write_slave: a transaction-level model
// checked every cycle plus directed scenarios with literal expectations.
module tb_axi4_lite_write_slave;

    localparam int unsigned NR = 16;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic [3:0]  rd_idx;
    logic [31:0] rd_data;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 ACLK = ~ACLK;

    axi4_lite_write_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (NR)
    ) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .AWADDR  (AWADDR),
        .AWPROT  (AWPROT),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .BRESP   (BRESP),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural model ----------------
    bit          m_aw_full, m_w_full, m_awready, m_wready, m_bvalid;
    logic [1:0]  m_bresp;
    logic [31:0] m_aw_addr, m_w_data;
    logic [3:0]  m_w_strb;
    logic [31:0] m_regs [NR];

    initial begin
        bit aw_hs, w_hs, b_hs, do_commit;
        forever begin
            @(posedge ACLK);
            if (ARESET) begin
                m_aw_full = 0; m_w_full = 0; m_awready = 0; m_wready = 0;
                m_bvalid = 0; m_bresp = 2'b00;
                for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
            end else begin
                aw_hs     = AWVALID && m_awready;
                w_hs      = WVALID && m_wready;
                b_hs      = m_bvalid && BREADY;
                do_commit = m_aw_full && m_w_full && !m_bvalid;
                if (do_commit) begin
                    if (m_aw_addr < NR * 4) begin
                        for (int b = 0; b < 4; b++) begin
                            if (m_w_strb[b]) m_regs[m_aw_addr[5:2]][8*b +: 8] = m_w_data[8*b +: 8];
                        end
                        m_bresp = 2'b00;
                    end else begin
                        m_bresp = 2'b10;
                    end
                    m_bvalid  = 1;
                    m_aw_full = 0;
                    m_w_full  = 0;
                end else if (b_hs) begin
                    m_bvalid = 0;
                end
                if (aw_hs) begin m_aw_full = 1; m_aw_addr = AWADDR; end
                if (w_hs) begin m_w_full = 1; m_w_data = WDATA; m_w_strb = WSTRB; end
                m_awready = !m_aw_full;
                m_wready  = !m_w_full;
            end
            #1;
            check("m_awready", AWREADY, m_awready);
            check("m_wready", WREADY, m_wready);
            check("m_bvalid", BVALID, m_bvalid);
            check("m_bresp", BRESP, m_bresp);
            check("m_rd_data", rd_data, m_regs[rd_idx]);
        end
    end

    // ---------------- Stimulus helpers ----------------
    // Drive for one edge starting at a negedge; returns on the following negedge.
    task automatic present(input bit aw, input logic [31:0] addr, input bit w,
                           input logic [31:0] data, input logic [3:0] strb);
        AWVALID = aw; AWADDR = addr; WVALID = w; WDATA = data; WSTRB = strb;
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0;
    endtask

    function automatic logic [31:0] exp_after_t3(input int idx);
        if (idx == 1) return 32'hDEADBEEF;
        if (idx == 2) return 32'h00220044;
        return 32'h0;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int         nb, first;
        bit         seen;
        logic [1:0] resp;
        ARESET = 1; AWVALID = 0; WVALID = 0; AWADDR = 0; AWPROT = 3'b010;
        WDATA = 0; WSTRB = 0; BREADY = 0; rd_idx = 0;

        // 1: reset for 3 edges, then release
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check("t1_rst_awready", AWREADY, 0);
            check("t1_rst_wready", WREADY, 0);
            check("t1_rst_bvalid", BVALID, 0);
        end
        ARESET = 0;
        @(negedge ACLK);
        check("t1_awready_up", AWREADY, 1);
        check("t1_wready_up", WREADY, 1);
        for (int i = 0; i < NR; i++) begin
            rd_idx = 4'(i);
            @(negedge ACLK);
            check("t1_reg_zero", rd_data, 0);
        end

        // 2: AW and W together, BREADY=1
        BREADY = 1; rd_idx = 1;
        present(1, 32'h04, 1, 32'hDEADBEEF, 4'hF);
        nb = 0; first = -1;
        for (int i = 0; i < 4; i++) begin
            if (BVALID) begin
                nb++;
                if (first < 0) first = i;
                check("t2_bresp", BRESP, 2'b00);
            end
            @(negedge ACLK);
        end
        check("t2_bvalid_count", nb, 1);
        check("t2_bvalid_latency", first, 1);
        check("t2_reg1", rd_data, 32'hDEADBEEF);

        // 3: W first, AW a few cycles later
        rd_idx = 2;
        present(0, 0, 1, 32'h11223344, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            check("t3_wready_wait", WREADY, 0);
            check("t3_awready_wait", AWREADY, 1);
            check("t3_no_bvalid", BVALID, 0);
            @(negedge ACLK);
        end
        present(1, 32'h08, 0, 0, 0);
        @(negedge ACLK);
        check("t3_bvalid", BVALID, 1);
        check("t3_bresp", BRESP, 2'b00);
        check("t3_reg2", rd_data, 32'h00220044);
        @(negedge ACLK);

        // 4: out-of-range write
        present(1, 32'h40, 1, 32'hFFFFFFFF, 4'hF);
        seen = 0; resp = 2'b00;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (BVALID) begin seen = 1; resp = BRESP; end
            @(negedge ACLK);
        end
        check("t4_bvalid_seen", 32'(seen), 1);
        check("t4_bresp_slverr", resp, 2'b10);
        for (int i = 0; i < NR; i++) begin
            rd_idx = 4'(i);
            @(negedge ACLK);
            check("t4_regs_unchanged", rd_data, exp_after_t3(i));
        end

        // 5: response back-pressure with a second write queued
        BREADY = 0; rd_idx = 4;
        present(1, 32'h0C, 1, 32'hA5A5A5A5, 4'hF);
        @(negedge ACLK);
        check("t5_bvalid_rise", BVALID, 1);
        check("t5_bresp", BRESP, 2'b00);
        present(1, 32'h10, 1, 32'h12345678, 4'b1100);
        check("t5_awready_full", AWREADY, 0);
        check("t5_wready_full", WREADY, 0);
        check("t5_bvalid_held", BVALID, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check("t5_bvalid_stable", BVALID, 1);
            check("t5_bresp_stable", BRESP, 2'b00);
            check("t5_reg4_pending", rd_data, 0);
        end
        BREADY = 1;
        @(negedge ACLK);
        check("t5_bvalid_drop", BVALID, 0);
        check("t5_reg4_not_yet", rd_data, 0);
        @(negedge ACLK);
        check("t5_second_bvalid", BVALID, 1);
        check("t5_reg4", rd_data, 32'h12340000);
        check("t5_awready_back", AWREADY, 1);
        rd_idx = 3;
        @(negedge ACLK);
        check("t5_reg3", rd_data, 32'hA5A5A5A5);
        check("t5_bvalid_clear", BVALID, 0);

        // 6: reset with only the AW slot occupied
        present(1, 32'h14, 0, 0, 0);
        check("t6_aw_full", AWREADY, 0);
        check("t6_w_empty", WREADY, 1);
        ARESET = 1;
        @(negedge ACLK);
        ARESET = 0;
        check("t6_rst_awready", AWREADY, 0);
        check("t6_rst_bvalid", BVALID, 0);
        check("t6_reg3_cleared", rd_data, 0);
        @(negedge ACLK);
        check("t6_awready_up", AWREADY, 1);
        check("t6_wready_up", WREADY, 1);
        rd_idx = 5;
        present(0, 0, 1, 32'hCAFEF00D, 4'hF);
        for (int i = 0; i < 4; i++) begin
            check("t6_no_bvalid", BVALID, 0);
            check("t6_w_waiting", WREADY, 0);
            check("t6_awready", AWREADY, 1);
            check("t6_reg5_zero", rd_data, 0);
            @(negedge ACLK);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
